// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the async FIFO read side
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} drain_state_e;
endpackage

// File: rtl/fifo_rd_drain_skid_buf.sv
// rd_skid_buf: circular output buffer absorbing the FIFO read latency
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                           rd_clk,
  input  logic                           rd_rstn,
  input  logic                           push,
  input  logic [Data_Width-1:0]          din,
  input  logic                           pop,
  output logic [Data_Width-1:0]          dout,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occ
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  logic [Data_Width-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  do_pop;
  assign do_pop = pop && (occ != '0);
  assign dout   = mem[rd_ptr];
  // pointers wrap at BUF_DEPTH, which need not be a power of two
  always_ff @(posedge rd_clk) begin
    if (!rd_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      occ <= occ + OW'(push) - OW'(do_pop);
    end
  end
endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: drains the async FIFO read port into a valid/ready stream
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  drain_en,
  input  logic                  empty,
  input  logic [Data_Width-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [Data_Width-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      words_drained
);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  drain_state_e  state, state_nx;
  logic          inflight_q;
  logic          xfer;
  logic [OW-1:0] occ;
  rd_skid_buf #(.Data_Width(Data_Width), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .rd_clk  (rd_clk),
    .rd_rstn (rd_rstn),
    .push    (inflight_q),
    .din     (data_out),
    .pop     (xfer),
    .dout    (m_data),
    .occ     (occ)
  );
  assign m_valid = occ != '0;
  assign xfer    = m_valid && m_ready;
  assign busy    = state != IDLE;
  // in-flight word reserves its slot, so a full buffer never depends on m_ready
  assign rd_en   = rd_rstn && (state == ACTIVE) && !empty &&
                   (({1'b0, occ} + (OW+1)'(inflight_q)) < (OW+1)'(BUF_DEPTH));
  always_comb begin
    state_nx = (state == IDLE)   ? (drain_en ? ACTIVE : IDLE) :
               (state == ACTIVE) ? (drain_en ? ACTIVE : FLUSH) :
               drain_en          ? ACTIVE :
               (!inflight_q && occ == '0) ? IDLE : FLUSH;
  end
  always_ff @(posedge rd_clk) begin
    if (!rd_rstn) begin
      state         <= IDLE;
      inflight_q    <= 1'b0;
      words_drained <= '0;
    end else begin
      state      <= state_nx;
      inflight_q <= rd_en;
      if (xfer) words_drained <= words_drained + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: FIFO model plus in-order scoreboard around fifo_rd_drain
module tb_fifo_rd_drain;
  localparam int DW = 8;
  logic          rd_clk = 0, rd_rstn = 0, drain_en = 0, empty = 1, m_ready = 0;
  logic [DW-1:0] data_out = '0;
  logic          rd_en, m_valid, busy, rd_en4, m_valid4, busy4;
  logic [DW-1:0] m_data, m_data4;
  logic [15:0]   words_drained;
  logic [3:0]    wd4;
  int            total = 0, bad = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          pop_pend = 0, prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  int            issued = 0, xfers = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain #(.Data_Width(DW), .BUF_DEPTH(3), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .drain_en(drain_en), .empty(empty),
    .data_out(data_out), .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .busy(busy), .words_drained(words_drained));

  fifo_rd_drain #(.Data_Width(DW), .BUF_DEPTH(3), .CNT_W(4)) dut4 (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .drain_en(drain_en), .empty(empty),
    .data_out(data_out), .rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .busy(busy4), .words_drained(wd4));

  // FIFO read port: a pop requested in one cycle shows on data_out the next
  always @(posedge rd_clk) begin
    #1;
    if (pop_pend && fifo_q.size() != 0) begin
      data_out = fifo_q.pop_front();
      exp_q.push_back(data_out);
    end
    pop_pend = 0;
    empty = fifo_q.size() == 0;
  end

  // protocol monitor and in-order scoreboard
  always @(negedge rd_clk) begin
    if (!rd_rstn) begin
      exp_q.delete();
      issued = 0;
      xfers = 0;
      prev_stall = 0;
      pop_pend = 0;
    end else begin
      total++;
      if (rd_en && empty) begin
        bad++;
        $display("FAIL rd_en_while_empty: rd_en=%b empty=%b at %0t", rd_en, empty, $time);
      end
      if (rd_en) issued++;
      total++;
      if (issued - xfers > 3) begin
        bad++;
        $display("FAIL occupancy_bound: outstanding=%0d max=3 at %0t", issued - xfers, $time);
      end
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%0h want valid=1 data=%0h at %0t",
                   m_valid, m_data, prev_data, $time);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL order: got %0h with no word expected at %0t", m_data, $time);
        end else begin
          if (m_data !== exp_q[0]) begin
            bad++;
            $display("FAIL order: got %0h want %0h at %0t", m_data, exp_q[0], $time);
          end
          void'(exp_q.pop_front());
        end
        xfers++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      pop_pend = rd_en;
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic push_words(input int n, input int start, input bit rnd);
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? DW'($urandom) : DW'(start + i));
    if (n > 0) empty = 0;
  endtask

  task automatic do_reset();
    rd_rstn = 0;
    drain_en = 0;
    m_ready = 0;
    fifo_q.delete();
    empty = 1;
    tick();
    tick();
    rd_rstn = 1;
  endtask

  task automatic test_reset();
    rd_rstn = 0;
    tick();
    tick();
    @(negedge rd_clk);
    total += 6;
    if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    if (m_data !== '0) begin bad++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (words_drained !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", words_drained); end
    if (wd4 !== '0) begin bad++; $display("FAIL reset_count4: got %0d want 0", wd4); end
    tick();
    rd_rstn = 1;
  endtask

  task automatic test_empty_idle();
    do_reset();
    drain_en = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      total += 2;
      if (rd_en !== 1'b0) begin bad++; $display("FAIL empty_rd_en: got %b want 0 cycle %0d", rd_en, i); end
      if (m_valid !== 1'b0) begin bad++; $display("FAIL empty_m_valid: got %b want 0 cycle %0d", m_valid, i); end
      if (i > 0) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL empty_busy: got %b want 1 cycle %0d", busy, i); end
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int first_rd = -1, first_v = -1;
    logic [DW-1:0] got[$];
    int gc[$];
    do_reset();
    push_words(8, 1, 0);
    drain_en = 1;
    m_ready = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge rd_clk);
      if (rd_en && first_rd < 0) first_rd = i;
      if (m_valid && first_v < 0) first_v = i;
      if (m_valid && m_ready) begin got.push_back(m_data); gc.push_back(i); end
      tick();
    end
    total += 3;
    if (first_v - first_rd !== 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", first_v - first_rd); end
    if (got.size() !== 8) begin bad++; $display("FAIL stream_count: got %0d want 8", got.size()); end
    if (words_drained !== 16'd8) begin bad++; $display("FAIL stream_drained: got %0d want 8", words_drained); end
    for (int k = 0; k < got.size(); k++) begin
      total += 2;
      if (got[k] !== DW'(k + 1)) begin bad++; $display("FAIL stream_data: got %0h want %0h", got[k], k + 1); end
      if (gc[k] !== gc[0] + k) begin bad++; $display("FAIL stream_rate: cycle %0d want %0d", gc[k], gc[0] + k); end
    end
  endtask

  task automatic test_backpressure();
    int n_rd = 0, n_got = 0;
    do_reset();
    push_words(8, 1, 0);
    drain_en = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge rd_clk);
      if (rd_en) n_rd++;
      if (m_valid) begin
        total++;
        if (m_data !== 8'h01) begin bad++; $display("FAIL bp_head: got %0h want 01", m_data); end
      end
      tick();
    end
    total++;
    if (n_rd !== 3) begin bad++; $display("FAIL bp_issues: got %0d want 3", n_rd); end
    m_ready = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge rd_clk);
      if (m_valid && m_ready) begin
        total++;
        if (m_data !== DW'(n_got + 1)) begin bad++; $display("FAIL bp_data: got %0h want %0h", m_data, n_got + 1); end
        n_got++;
      end
      tick();
    end
    total += 2;
    if (n_got !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", n_got); end
    if (words_drained !== 16'd8) begin bad++; $display("FAIL bp_drained: got %0d want 8", words_drained); end
  endtask

  task automatic test_flush();
    int n_rd = 0, n_got = 0, w = 0;
    do_reset();
    push_words(10, 1, 0);
    drain_en = 1;
    while (n_rd == 0 && w < 10) begin
      @(negedge rd_clk);
      if (rd_en) n_rd++;
      w++;
      tick();
    end
    drain_en = 0;
    for (int j = 0; j < 15; j++) begin
      if (j == 5) m_ready = 1;
      @(negedge rd_clk);
      if (rd_en) n_rd++;
      if (m_valid) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_hi: got %b want 1", busy); end
      end
      if (m_valid && m_ready) n_got++;
      tick();
    end
    total += 5;
    if (n_rd !== 2) begin bad++; $display("FAIL flush_issues: got %0d want 2", n_rd); end
    if (n_got !== 2) begin bad++; $display("FAIL flush_delivered: got %0d want 2", n_got); end
    if (words_drained !== 16'd2) begin bad++; $display("FAIL flush_drained: got %0d want 2", words_drained); end
    if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_lo: got %b want 0", busy); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", m_valid); end
    drain_en = 1;
    for (int j = 0; j < 30; j++) tick();
    total++;
    if (words_drained !== 16'd10) begin bad++; $display("FAIL flush_resume: got %0d want 10", words_drained); end
  endtask

  task automatic test_reset_mid();
    int n_rd = 0, w = 0;
    bit seen = 0;
    do_reset();
    push_words(10, 1, 0);
    drain_en = 1;
    while (n_rd < 3 && w < 12) begin
      @(negedge rd_clk);
      if (rd_en) n_rd++;
      w++;
      tick();
    end
    total++;
    if (n_rd !== 3) begin bad++; $display("FAIL mid_setup: issues %0d want 3", n_rd); end
    rd_rstn = 0;
    @(negedge rd_clk);
    total++;
    if (rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %b want 0", rd_en); end
    tick();
    rd_rstn = 1;
    @(negedge rd_clk);
    total += 3;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", m_valid); end
    if (words_drained !== '0) begin bad++; $display("FAIL mid_count: got %0d want 0", words_drained); end
    if (wd4 !== '0) begin bad++; $display("FAIL mid_count4: got %0d want 0", wd4); end
    tick();
    m_ready = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge rd_clk);
      if (m_valid && m_ready && !seen) begin
        seen = 1;
        total++;
        if (m_data !== 8'h04) begin bad++; $display("FAIL mid_first: got %0h want 04", m_data); end
      end
      tick();
    end
    total += 2;
    if (!seen) begin bad++; $display("FAIL mid_timeout: got no transfer want one"); end
    if (words_drained !== 16'd7) begin bad++; $display("FAIL mid_drained: got %0d want 7", words_drained); end
  endtask

  task automatic test_wrap();
    do_reset();
    push_words(17, 0, 1);
    drain_en = 1;
    m_ready = 1;
    for (int i = 0; i < 40; i++) tick();
    total += 2;
    if (words_drained !== 16'd17) begin bad++; $display("FAIL wrap_count16: got %0d want 17", words_drained); end
    if (wd4 !== 4'd1) begin bad++; $display("FAIL wrap_count4: got %0d want 1", wd4); end
  endtask

  task automatic test_random();
    int sent = 0;
    logic [15:0] want;
    do_reset();
    drain_en = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin push_words(1, 0, 1); sent++; end
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) drain_en = !drain_en;
      tick();
    end
    drain_en = 1;
    m_ready = 1;
    for (int i = 0; i < 300 && (fifo_q.size() != 0 || m_valid); i++) tick();
    for (int i = 0; i < 5; i++) tick();
    want = 16'(sent);
    total += 3;
    if (words_drained !== want) begin bad++; $display("FAIL rand_count: got %0d want %0d", words_drained, want); end
    if (wd4 !== want[3:0]) begin bad++; $display("FAIL rand_count4: got %0d want %0d", wd4, want[3:0]); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rand_drain: valid %b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_empty_idle();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
